// File: rtl/video_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
package video_pkg;

  // Default 640x480@60 segment lengths (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Per-pixel control carried alongside the colour fetch.
  // hsync/vsync are "in sync region" flags; polarity is applied at the output.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } video_sync_t;

endpackage

// File: rtl/video_delay_line.sv
// Enabled shift register, DEPTH stages of WIDTH bits, synchronous reset to 0.
module video_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_sr;

  // Shift one stage per enable; stage 0 takes the new value
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator and pixel output stage.
// Optional feature: define VIDEO_TEST_PATTERN_EN to add i_test_pattern and
// an 8-bar colour pattern that replaces i_video_rdata while selected.
module video_timing_generator
  import video_pkg::*;
#(
  parameter int CLOCK_DIV     = 2,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_FP          = DEF_H_FP,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BP          = DEF_H_BP,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_FP          = DEF_V_FP,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BP          = DEF_V_BP,
  parameter int PIXEL_LATENCY = 2,
  parameter bit SYNC_POL      = 1'b0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_hblank,
  output logic        o_vblank,
  output logic [9:0]  o_pos_x,
  output logic [9:0]  o_pos_y,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic        i_test_pattern,
`endif
  input  logic [31:0] i_video_rdata,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [10:0]   r_h_count, r_v_count;
  logic          w_tick;
  logic          w_h_active, w_v_active, w_h_sync, w_v_sync;
  video_sync_t   r_s0, w_dly;
  logic [23:0]   w_rgb;
  logic          w_unused;

  assign w_tick     = (r_div == DW'(CLOCK_DIV - 1));
  assign w_h_active = (r_h_count < 11'(H_ACTIVE));
  assign w_v_active = (r_v_count < 11'(V_ACTIVE));
  assign w_h_sync   = (r_h_count >= 11'(H_ACTIVE + H_FP)) &&
                      (r_h_count <  11'(H_ACTIVE + H_FP + H_SYNC));
  assign w_v_sync   = (r_v_count >= 11'(V_ACTIVE + V_FP)) &&
                      (r_v_count <  11'(V_ACTIVE + V_FP + V_SYNC));
  assign w_unused   = ^i_video_rdata[31:24];

  // Pixel clock divider: one tick every CLOCK_DIV system clocks
  always_ff @(posedge i_clock) begin
    if (i_reset)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DW'(1);
  end

  // Raster counters; line wrap and frame wrap land on the same tick
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_tick) begin
      if (r_h_count == 11'(H_TOT - 1)) begin
        r_h_count <= '0;
        r_v_count <= (r_v_count == 11'(V_TOT - 1)) ? 11'd0 : r_v_count + 11'd1;
      end else begin
        r_h_count <= r_h_count + 11'd1;
      end
    end
  end

  // Stage 0: position/region flags for the controller, plus control for the delay line
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_hblank <= 1'b0;
      o_vblank <= 1'b0;
      o_pos_x  <= '0;
      o_pos_y  <= '0;
      r_s0     <= '0;
    end else if (w_tick) begin
      o_hblank <= w_h_active;
      o_vblank <= w_v_active;
      o_pos_x  <= w_h_active ? r_h_count[9:0] : 10'd0;
      o_pos_y  <= w_v_active ? r_v_count[9:0] : 10'd0;
      r_s0     <= '{de: w_h_active & w_v_active, hsync: w_h_sync, vsync: w_v_sync};
    end
  end

  // Match the controller's read latency; output register adds the final tick
  video_delay_line #(.DEPTH(PIXEL_LATENCY), .WIDTH($bits(video_sync_t))) u_sync_dly (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (w_tick),
    .i_d     (r_s0),
    .o_q     (w_dly)
  );

`ifdef VIDEO_TEST_PATTERN_EN
  logic [9:0] w_dly_x;
  logic [2:0] w_bar;

  // Column follows the same path as de so the bar index lines up with the pixel
  video_delay_line #(.DEPTH(PIXEL_LATENCY), .WIDTH(10)) u_x_dly (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (w_tick),
    .i_d     (o_pos_x),
    .o_q     (w_dly_x)
  );

  assign w_bar = 3'(w_dly_x / 10'd80);
  assign w_rgb = i_test_pattern ? {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}}
                                : i_video_rdata[23:0];
`else
  assign w_rgb = i_video_rdata[23:0];
`endif

  // Output register: colour gated by de, syncs mapped to the asserted polarity
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      {o_red, o_green, o_blue} <= 24'h0;
      o_de    <= 1'b0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
    end else if (w_tick) begin
      {o_red, o_green, o_blue} <= w_dly.de ? w_rgb : 24'h0;
      o_de    <= w_dly.de;
      o_hsync <= w_dly.hsync ? SYNC_POL : ~SYNC_POL;
      o_vsync <= w_dly.vsync ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Randomized self-checking bench; a reduced raster keeps whole frames short.
module tb_video_timing_generator;

  localparam int CD = 2;
  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int PL = 3;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata;
  logic        hblank, vblank, de, hsync, vsync;
  logic [9:0]  pos_x, pos_y;
  logic [7:0]  red, green, blue;
`ifdef VIDEO_TEST_PATTERN_EN
  logic        tp = 1'b0;
`endif

  video_timing_generator #(
    .CLOCK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_LATENCY(PL), .SYNC_POL(SP)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .o_hblank(hblank), .o_vblank(vblank), .o_pos_x(pos_x), .o_pos_y(pos_y),
`ifdef VIDEO_TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .i_video_rdata(rdata),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_de(de), .o_hsync(hsync), .o_vsync(vsync)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: tick index since release -> raster position
  int nt = 0;          // ticks seen since reset release
  int kc = 0;          // clocks since reset release
  int cyc = 0;         // free-running clock count
  logic [23:0] e_rgb = 24'h0;
  int last_hs = -1, last_vs = -1, vs_lo = -1, last_hb = -1;
  logic p_hs = 1'b1, p_vs = 1'b1, p_hb = 1'b0;
  logic [9:0] p_px = 10'd0;

  function automatic bit in_hsync(int x); return x >= HA + HF && x < HA + HF + HS; endfunction
  function automatic bit in_vsync(int y); return y >= VA + VF && y < VA + VF + VS; endfunction

  task automatic step();
    int m, x, y, mo, xo, yo;
    bit de_o;
    rdata = $urandom;
    @(posedge clk);
    cyc++;
    if (rst) begin
      nt = 0; kc = 0; e_rgb = 24'h0;
    end else begin
      if (kc % CD == CD - 1) begin
        nt++;
        mo = nt - PL - 2;
        de_o = (mo >= 0) && ((mo % FT) % HT < HA) && ((mo % FT) / HT < VA);
        e_rgb = de_o ? rdata[23:0] : 24'h0;
      end
      kc++;
    end
    #1;
    // stage 0 expectation
    if (nt == 0) begin
      chk("hblank", hblank, 0); chk("vblank", vblank, 0);
      chk("pos_x", pos_x, 0);   chk("pos_y", pos_y, 0);
    end else begin
      m = (nt - 1) % FT; x = m % HT; y = m / HT;
      chk("hblank", hblank, x < HA);
      chk("vblank", vblank, y < VA);
      chk("pos_x", pos_x, (x < HA) ? x : 0);
      chk("pos_y", pos_y, (y < VA) ? y : 0);
    end
    // output stage expectation
    mo = nt - PL - 2;
    if (mo < 0) begin
      chk("de", de, 0); chk("hsync", hsync, !SP); chk("vsync", vsync, !SP);
    end else begin
      xo = (mo % FT) % HT; yo = (mo % FT) / HT;
      chk("de", de, (xo < HA) && (yo < VA));
      chk("hsync", hsync, in_hsync(xo) ? SP : !SP);
      chk("vsync", vsync, in_vsync(yo) ? SP : !SP);
    end
    chk("rgb", {red, green, blue}, e_rgb);
    // edge/period observations
    if (rst) begin
      last_hs = -1; last_vs = -1; vs_lo = -1; last_hb = -1;
    end else begin
      if (p_hs && !hsync) begin
        if (last_hs >= 0) chk("hsync_period", cyc - last_hs, HT * CD);
        last_hs = cyc;
      end
      if (p_vs && !vsync) begin
        if (last_vs >= 0) chk("vsync_period", cyc - last_vs, FT * CD);
        last_vs = cyc; vs_lo = cyc;
      end
      if (!p_vs && vsync && vs_lo >= 0) chk("vsync_low", cyc - vs_lo, VS * HT * CD);
      if (p_hb && !hblank) begin
        chk("hblank_fall_x", p_px, HA - 1);
        if (last_hb >= 0) chk("hblank_period", cyc - last_hb, HT * CD);
        last_hb = cyc;
      end
    end
    p_hs = hsync; p_vs = vsync; p_hb = hblank; p_px = pos_x;
  endtask

  initial begin
    rst = 1'b1;
    rdata = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2 * FT * CD + 300) step();
    // mid-frame reset at a random point
    repeat ($urandom_range(1, FT * CD - 1)) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2 * FT * CD + 200) step();
    // short reset landing between ticks
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (FT * CD + 100) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
